// File: rtl/mem_bus_responder_pkg.sv
// Shared definitions for mem_bus_responder: response FSM state codes and request FIFO entry layout.
package mem_bus_responder_pkg;

    typedef enum logic [1:0] {
        RESP_IDLE    = 2'd0,
        RESP_ACCESS  = 2'd1,
        RESP_RESPOND = 2'd2
    } resp_state_t;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;

    // A FIFO entry is {is_write, addr, wdata} with wdata in the least significant bits.
    function automatic int entry_w(input int aw, input int dw);
        return 1 + aw + dw;
    endfunction

endpackage

// File: rtl/mem_bus_responder_if.sv
// Shared CPU/memory bus: request strobes, tri-stated addr/data/is_bus_busy lines and done flags.
interface mem_bus_responder_if
    import mem_bus_responder_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W
) ();

    logic              read_q;
    logic              write_q;
    logic              req_oe;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;

    logic              rsp_oe;
    logic [ADDR_W-1:0] rsp_addr;
    logic [DATA_W-1:0] rsp_data;
    logic              read_dn;
    logic              write_dn;

    wire  [ADDR_W-1:0] addr;
    wire  [DATA_W-1:0] data;
    wire               is_bus_busy;

    // Requester and responder share the lines; the protocol keeps their enables exclusive.
    assign addr        = rsp_oe ? rsp_addr : 'z;
    assign addr        = req_oe ? req_addr : 'z;
    assign data        = rsp_oe ? rsp_data : 'z;
    assign data        = req_oe ? req_data : 'z;
    assign is_bus_busy = rsp_oe ? 1'b1 : 1'bz;

    modport slave (
        input  read_q, write_q, addr, data,
        output rsp_oe, rsp_addr, rsp_data, read_dn, write_dn
    );

    modport master (
        output read_q, write_q, req_oe, req_addr, req_data,
        input  addr, data, is_bus_busy, read_dn, write_dn, rsp_oe
    );

endinterface

// File: rtl/mem_req_fifo.sv
// In-order request FIFO for mem_bus_responder; a push while full is ignored even if a pop occurs on the same edge.
module mem_req_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[PW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side bus slave: queues read/write pulses, performs them on a word RAM and answers each with one bus cycle.
// Define MEM_BUS_RESPONDER_STATS_EN to add the rd_cnt/wr_cnt response counters.
module mem_bus_responder
    import mem_bus_responder_pkg::*;
#(
    parameter int ADDR_W     = BUS_ADDR_W,
    parameter int DATA_W     = BUS_DATA_W,
    parameter int MEM_WORDS  = 256,
    parameter int FIFO_DEPTH = 4,
    parameter int LAT        = 1
) (
    input  logic               clk,
    input  logic               rst,
    mem_bus_responder_if.slave bus,
    output logic               ovf,
    output logic               err
`ifdef MEM_BUS_RESPONDER_STATS_EN
    ,
    output logic [15:0]        rd_cnt,
    output logic [15:0]        wr_cnt
`endif
);

    localparam int IDX_W   = $clog2(MEM_WORDS);
    localparam int ENTRY_W = entry_w(ADDR_W, DATA_W);
    localparam int CNT_W   = (LAT > 1) ? $clog2(LAT) : 1;

    logic [DATA_W-1:0]  ram [MEM_WORDS];
    resp_state_t        state;
    logic [CNT_W-1:0]   cnt;
    logic               cur_wr;
    logic [ADDR_W-1:0]  cur_addr;
    logic [DATA_W-1:0]  cur_wdata;
    logic [IDX_W-1:0]   cur_idx;

    logic               req;
    logic               take;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic               ram_we;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] pop_entry;

    // Requests are only sampled outside RESPOND; a write wins when both strobes are high.
    assign req        = bus.read_q | bus.write_q;
    assign take       = req && (state != RESP_RESPOND);
    assign push       = take && !full;
    assign push_entry = {bus.write_q, bus.addr, bus.data};
    assign pop        = !empty && ((state == RESP_IDLE) || (state == RESP_RESPOND));
    assign cur_idx    = cur_addr[IDX_W+1:2];
    assign ram_we     = (state == RESP_ACCESS) && (cnt == '0) && cur_wr;

    mem_req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (pop_entry),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[cur_idx] <= cur_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= RESP_IDLE;
            cnt          <= '0;
            cur_wr       <= 1'b0;
            cur_addr     <= '0;
            cur_wdata    <= '0;
            bus.rsp_oe   <= 1'b0;
            bus.rsp_addr <= '0;
            bus.rsp_data <= '0;
            bus.read_dn  <= 1'b0;
            bus.write_dn <= 1'b0;
            ovf          <= 1'b0;
            err          <= 1'b0;
`ifdef MEM_BUS_RESPONDER_STATS_EN
            rd_cnt       <= '0;
            wr_cnt       <= '0;
`endif
        end else begin
            if (take && full) begin
                ovf <= 1'b1;
            end
            if (take && bus.read_q && bus.write_q) begin
                err <= 1'b1;
            end

            case (state)
                RESP_IDLE: begin
                    if (pop) begin
                        {cur_wr, cur_addr, cur_wdata} <= pop_entry;
                        cnt   <= CNT_W'(LAT - 1);
                        state <= RESP_ACCESS;
                    end
                end
                RESP_ACCESS: begin
                    // The RAM write commits on this same edge, so a read always sees older writes.
                    if (cnt == '0) begin
                        state        <= RESP_RESPOND;
                        bus.rsp_oe   <= 1'b1;
                        bus.rsp_addr <= cur_addr;
                        bus.rsp_data <= cur_wr ? cur_wdata : ram[cur_idx];
                        bus.read_dn  <= !cur_wr;
                        bus.write_dn <= cur_wr;
`ifdef MEM_BUS_RESPONDER_STATS_EN
                        if (cur_wr) begin
                            wr_cnt <= wr_cnt + 16'd1;
                        end else begin
                            rd_cnt <= rd_cnt + 16'd1;
                        end
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP_RESPOND: begin
                    bus.rsp_oe   <= 1'b0;
                    bus.read_dn  <= 1'b0;
                    bus.write_dn <= 1'b0;
                    if (pop) begin
                        {cur_wr, cur_addr, cur_wdata} <= pop_entry;
                        cnt   <= CNT_W'(LAT - 1);
                        state <= RESP_ACCESS;
                    end else begin
                        state <= RESP_IDLE;
                    end
                end
                default: begin
                    state <= RESP_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: three instances with LAT=1, LAT=3 and LAT=4 share one clock.
module tb_mem_bus_responder;

    typedef struct packed {
        logic        wr;
        logic        rd;
        logic        busy;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] at;
    } rsp_t;

    logic        clk = 1'b0;
    logic [2:0]  rst_n;
    logic [2:0]  drv_rd;
    logic [2:0]  drv_wr;
    logic [2:0]  drv_oe;
    logic [31:0] drv_addr [3];
    logic [31:0] drv_data [3];

    logic [2:0]  obs_oe;
    logic [2:0]  obs_busy;
    logic [2:0]  obs_rd;
    logic [2:0]  obs_wr;
    logic [2:0]  obs_ovf;
    logic [2:0]  obs_err;
    logic [31:0] obs_addr [3];
    logic [31:0] obs_data [3];
`ifdef MEM_BUS_RESPONDER_STATS_EN
    logic [15:0] rd_cnt_w [3];
    logic [15:0] wr_cnt_w [3];
`endif

    int   cyc   = 0;
    int   stray = 0;
    int   total = 0;
    int   bad   = 0;
    rsp_t log_q [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_bus_responder_if bus ();

        assign bus.read_q   = drv_rd[g];
        assign bus.write_q  = drv_wr[g];
        assign bus.req_oe   = drv_oe[g];
        assign bus.req_addr = drv_addr[g];
        assign bus.req_data = drv_data[g];

        mem_bus_responder #(
            .LAT ((g == 0) ? 1 : ((g == 1) ? 3 : 4))
        ) dut (
            .clk    (clk),
            .rst    (rst_n[g]),
            .bus    (bus.slave),
            .ovf    (obs_ovf[g]),
            .err    (obs_err[g])
`ifdef MEM_BUS_RESPONDER_STATS_EN
            ,
            .rd_cnt (rd_cnt_w[g]),
            .wr_cnt (wr_cnt_w[g])
`endif
        );

        assign obs_oe[g]   = bus.rsp_oe;
        assign obs_busy[g] = bus.is_bus_busy;
        assign obs_rd[g]   = bus.read_dn;
        assign obs_wr[g]   = bus.write_dn;
        assign obs_addr[g] = bus.addr;
        assign obs_data[g] = bus.data;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Every negedge with a responder driving the bus is logged; done flags without a drive are counted.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (obs_oe[i]) begin
                rsp_t r;
                r.wr   = obs_wr[i];
                r.rd   = obs_rd[i];
                r.busy = obs_busy[i];
                r.a    = obs_addr[i];
                r.d    = obs_data[i];
                r.at   = cyc;
                log_q.push_back(r);
            end else if (obs_rd[i] || obs_wr[i]) begin
                stray++;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int inst, input logic rd, input logic wr,
                                 input logic [31:0] a, input logic [31:0] d, output int cap);
        cap            = cyc + 1;
        drv_rd[inst]   = rd;
        drv_wr[inst]   = wr;
        drv_oe[inst]   = 1'b1;
        drv_addr[inst] = a;
        drv_data[inst] = d;
        @(negedge clk);
        drv_rd[inst]   = 1'b0;
        drv_wr[inst]   = 1'b0;
        drv_oe[inst]   = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkResp(input string tag, input int idx, input logic wr,
                             input logic [31:0] a, input logic [31:0] d, input int at);
        if (idx < log_q.size()) begin
            checkOutput({tag, "_kind"}, {29'd0, log_q[idx].wr, log_q[idx].rd, log_q[idx].busy},
                        {29'd0, wr, !wr, 1'b1});
            checkOutput({tag, "_addr"}, log_q[idx].a, a);
            checkOutput({tag, "_data"}, log_q[idx].d, d);
            checkOutput({tag, "_cycle"}, log_q[idx].at, at);
        end
    endtask

    initial begin
        int cap;
        int cap2;
        int cap3;
        int cap0;

        rst_n  = '0;
        drv_rd = '0;
        drv_wr = '0;
        drv_oe = '0;
        for (int i = 0; i < 3; i++) begin
            drv_addr[i] = '0;
            drv_data[i] = '0;
        end
        repeat (3) @(negedge clk);
        rst_n = '1;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("reset_outs_u%0d", i),
                        32'({obs_oe[i], obs_rd[i], obs_wr[i], obs_ovf[i], obs_err[i]}), 32'd0);
        end

        // Write then read back, LAT=1.
        log_q.delete();
        applyStimulus(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, cap);
        applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, cap2);
        waitCycles(8);
        checkOutput("wr_rd_count", log_q.size(), 2);
        checkResp("wr_rsp", 0, 1'b1, 32'h10, 32'hDEADBEEF, cap + 2);
        checkResp("rd_rsp", 1, 1'b0, 32'h10, 32'hDEADBEEF, cap2 + 3);

        // Back-to-back reads of preloaded words 1, 2, 3.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 1'b0, 1'b1, 32'(4 * k), 32'(k + 1), cap);
            waitCycles(4);
        end
        log_q.delete();
        applyStimulus(0, 1'b1, 1'b0, 32'h0, 32'h0, cap0);
        applyStimulus(0, 1'b1, 1'b0, 32'h4, 32'h0, cap);
        applyStimulus(0, 1'b1, 1'b0, 32'h8, 32'h0, cap);
        waitCycles(10);
        checkOutput("b2b_count", log_q.size(), 3);
        checkResp("b2b0", 0, 1'b0, 32'h0, 32'd1, cap0 + 2);
        checkResp("b2b1", 1, 1'b0, 32'h4, 32'd2, cap0 + 4);
        checkResp("b2b2", 2, 1'b0, 32'h8, 32'd3, cap0 + 6);
        checkOutput("b2b_flags", 32'({obs_ovf[0], obs_err[0]}), 32'd0);

        // Simultaneous strobes enqueue only the write; reads at 0x20 and wrapped 0x423 both hit word 8.
        log_q.delete();
        applyStimulus(0, 1'b1, 1'b1, 32'h20, 32'h5A, cap);
        waitCycles(4);
        applyStimulus(0, 1'b1, 1'b0, 32'h20, 32'h0, cap2);
        waitCycles(4);
        applyStimulus(0, 1'b1, 1'b0, 32'h423, 32'h0, cap3);
        waitCycles(4);
        checkOutput("both_count", log_q.size(), 3);
        checkResp("both_wr", 0, 1'b1, 32'h20, 32'h5A, cap + 2);
        checkResp("both_rd", 1, 1'b0, 32'h20, 32'h5A, cap2 + 2);
        checkResp("wrap_rd", 2, 1'b0, 32'h423, 32'h5A, cap3 + 2);
        checkOutput("both_err", 32'(obs_err[0]), 32'd1);
        checkOutput("both_ovf", 32'(obs_ovf[0]), 32'd0);

        rst_n[0] = 1'b0;
        #1;
        checkOutput("rst_clears_err", 32'(obs_err[0]), 32'd0);
        waitCycles(1);
        rst_n[0] = 1'b1;
        waitCycles(1);

        // Overflow on the LAT=4 instance: six consecutive reads, the sixth is dropped.
        for (int k = 0; k < 6; k++) begin
            applyStimulus(2, 1'b0, 1'b1, 32'(32'h100 + 4 * k), 32'(32'hA0 + k), cap);
            waitCycles(8);
        end
        log_q.delete();
        cap0 = 0;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(2, 1'b1, 1'b0, 32'(32'h100 + 4 * k), 32'h0, cap);
            if (k == 0) cap0 = cap;
        end
        waitCycles(35);
        checkOutput("ovf_count", log_q.size(), 5);
        for (int k = 0; k < 5; k++) begin
            checkResp($sformatf("ovf_rsp%0d", k), k, 1'b0, 32'(32'h100 + 4 * k),
                      32'(32'hA0 + k), cap0 + 5 + 5 * k);
        end
        checkOutput("ovf_flag", 32'(obs_ovf[2]), 32'd1);
        checkOutput("ovf_no_err", 32'(obs_err[2]), 32'd0);

        // Latency on the LAT=3 instance: driven from E0+4, logged on exactly one negedge.
        applyStimulus(1, 1'b0, 1'b1, 32'h40, 32'h12345678, cap);
        waitCycles(8);
        log_q.delete();
        applyStimulus(1, 1'b1, 1'b0, 32'h40, 32'h0, cap);
        waitCycles(10);
        checkOutput("lat3_count", log_q.size(), 1);
        checkResp("lat3_rd", 0, 1'b0, 32'h40, 32'h12345678, cap + 4);

        // Reset while the response is on the bus releases it at once.
        applyStimulus(1, 1'b1, 1'b0, 32'h40, 32'h0, cap);
        waitCycles(4);
        checkOutput("mid_rsp_oe", 32'(obs_oe[1]), 32'd1);
        rst_n[1] = 1'b0;
        #1;
        checkOutput("rst_rsp_release", 32'({obs_oe[1], obs_rd[1], obs_wr[1]}), 32'd0);
        waitCycles(1);
        rst_n[1] = 1'b1;
        waitCycles(2);

        // Reset mid-ACCESS with a second request still queued: nothing is answered afterwards.
        log_q.delete();
        applyStimulus(1, 1'b1, 1'b0, 32'h40, 32'h0, cap);
        applyStimulus(1, 1'b1, 1'b0, 32'h44, 32'h0, cap2);
        waitCycles(1);
        rst_n[1] = 1'b0;
        #1;
        checkOutput("rst_acc_oe", 32'(obs_oe[1]), 32'd0);
        waitCycles(2);
        rst_n[1] = 1'b1;
        waitCycles(12);
        checkOutput("rst_acc_no_rsp", log_q.size(), 0);

        checkOutput("stray_done_flags", stray, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
